// File: rtl/multi_blink_controller.sv
// N-channel LED pattern generator: shared tick prescaler, per-channel off/on/blink/burst.
// led and tick are decoded combinationally from registered state.
module multi_blink_controller #(
   parameter int unsigned N_CH     = 4,
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned BURST_W  = 8,
   parameter int unsigned TICK_DIV = 100000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [2*N_CH-1:0]        mode,
   input  logic [CNT_W*N_CH-1:0]    period,
   input  logic [CNT_W*N_CH-1:0]    on_time,
   input  logic [BURST_W*N_CH-1:0]  burst_len,
   input  logic [N_CH-1:0]          start,
   output logic [N_CH-1:0]          led,
   output logic [N_CH-1:0]          busy,
   output logic                     tick
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_ON    = 2'b01;
   localparam logic [1:0] MODE_BLINK = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   typedef enum logic {ST_IDLE, ST_RUN} burst_st_e;

   logic [PRE_W-1:0] pre_q;

   assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst)       pre_q <= '0;
      else if (tick) pre_q <= '0;
      else           pre_q <= pre_q + PRE_W'(1);
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      logic [1:0]         mode_w;
      logic [1:0]         mode_q;
      logic [CNT_W-1:0]   per_w;
      logic [CNT_W-1:0]   on_w;
      logic [CNT_W-1:0]   cnt_q;
      logic [BURST_W-1:0] len_w;
      logic [BURST_W-1:0] rem_q;
      burst_st_e          st_q;
      logic               wrap_c;
      logic               dis_c;
      logic               pat_c;

      assign mode_w = mode[2*g +: 2];
      assign per_w  = period[CNT_W*g +: CNT_W];
      assign on_w   = on_time[CNT_W*g +: CNT_W];
      assign len_w  = burst_len[BURST_W*g +: BURST_W];

      // >= rather than == so a shrinking period never lets cnt run away
      assign wrap_c = (per_w == '0) || (cnt_q >= per_w - CNT_W'(1));
      assign dis_c  = mode_w[1] && (per_w == '0);
      assign pat_c  = (per_w != '0) && (cnt_q < on_w);

      always_ff @(posedge clk) begin
         if (rst) begin
            mode_q <= MODE_OFF;
            cnt_q  <= '0;
            rem_q  <= '0;
            st_q   <= ST_IDLE;
         end else begin
            mode_q <= mode_w;
            if ((mode_w != mode_q) || dis_c) begin
               cnt_q <= '0;
               rem_q <= '0;
               st_q  <= ST_IDLE;
            end else if ((st_q == ST_IDLE) && (mode_w == MODE_BURST) &&
                         start[g] && (len_w != '0)) begin
               cnt_q <= '0;
               rem_q <= len_w;
               st_q  <= ST_RUN;
            end else if (tick) begin
               cnt_q <= wrap_c ? '0 : cnt_q + CNT_W'(1);
               if ((st_q == ST_RUN) && wrap_c) begin
                  rem_q <= rem_q - BURST_W'(1);
                  if (rem_q == BURST_W'(1)) st_q <= ST_IDLE;
               end
            end
         end
      end

      assign busy[g] = (st_q == ST_RUN);
      assign led[g]  = (mode_q == MODE_ON) ||
                       ((mode_q == MODE_BLINK) && pat_c) ||
                       ((mode_q == MODE_BURST) && (st_q == ST_RUN) && pat_c);
   end

endmodule

// File: tb/tb_multi_blink_controller.sv
// Directed bench for multi_blink_controller with TICK_DIV=4; expectations are hand-derived.
module tb_multi_blink_controller;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = 16;
   localparam int unsigned BW = 8;

   localparam logic [1:0] M_OFF   = 2'b00;
   localparam logic [1:0] M_ON    = 2'b01;
   localparam logic [1:0] M_BLINK = 2'b10;
   localparam logic [1:0] M_BURST = 2'b11;

   logic            clk;
   logic            rst;
   logic [2*N-1:0]  mode;
   logic [CW*N-1:0] period;
   logic [CW*N-1:0] on_time;
   logic [BW*N-1:0] burst_len;
   logic [N-1:0]    start;
   logic [N-1:0]    led;
   logic [N-1:0]    busy;
   logic            tick;

   int checks;
   int failures;
   int k;

   multi_blink_controller #(
      .N_CH(N), .CNT_W(CW), .BURST_W(BW), .TICK_DIV(4)
   ) dut (
      .clk(clk), .rst(rst), .mode(mode), .period(period), .on_time(on_time),
      .burst_len(burst_len), .start(start), .led(led), .busy(busy), .tick(tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      k++;
   endtask

   task automatic align(input int ph);
      while ((k % 4) != ph) step();
   endtask

   task automatic set_ch(input int ch, input logic [1:0] m, input int per, input int on, input int len);
      mode[2*ch +: 2]       = m;
      period[CW*ch +: CW]   = CW'(per);
      on_time[CW*ch +: CW]  = CW'(on);
      burst_len[BW*ch +: BW] = BW'(len);
   endtask

   initial begin
      checks = 0; failures = 0; k = 0;
      rst = 1'b1; mode = '0; period = '0; on_time = '0; burst_len = '0; start = '0;

      // reset state, then ch0 blink period 4 / on 1
      set_ch(0, M_BLINK, 4, 1, 0);
      step();
      k = 0;
      check("rst_tick", 32'(tick), 32'(0));
      check("rst_led",  32'(led),  32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      rst = 1'b0;
      for (int i = 0; i < 48; i++) begin
         step();
         check("t1_led0",  32'(led[0]),   32'((k % 16) < 4));
         check("t1_tick",  32'(tick),     32'((k % 4) == 3));
         check("t1_other", 32'(led[3:1]), 32'(0));
      end

      // ch1 burst of 3, retrigger and burst_len change mid-burst ignored
      set_ch(1, M_BURST, 2, 1, 3);
      step();
      align(3);
      start[1] = 1'b1;
      step();
      for (int j = 0; j < 32; j++) begin
         check("t2_busy1", 32'(busy[1]), 32'(j < 24));
         check("t2_led1",  32'(led[1]),  32'((j < 24) && ((j / 4) % 2 == 0)));
         start[1] = (j == 9);
         if (j == 12) burst_len[BW +: BW] = BW'(7);
         step();
      end

      // boundaries: on_time 0 / on_time > period / period 0 / burst_len 0
      set_ch(2, M_BLINK, 4, 0, 0);
      set_ch(3, M_BLINK, 4, 5, 0);
      step();
      for (int i = 0; i < 16; i++) begin
         check("t3_on0",   32'(led[2]), 32'(0));
         check("t3_onbig", 32'(led[3]), 32'(1));
         step();
      end
      set_ch(2, M_BLINK, 0, 2, 0);
      step();
      for (int i = 0; i < 8; i++) begin
         check("t3_per0", 32'(led[2]), 32'(0));
         step();
      end
      set_ch(3, M_BURST, 4, 2, 0);
      step();
      start[3] = 1'b1;
      step();
      start[3] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("t3_len0_busy", 32'(busy[3]), 32'(0));
         check("t3_len0_led",  32'(led[3]),  32'(0));
         step();
      end
      set_ch(3, M_BURST, 0, 2, 3);
      start[3] = 1'b1;
      step();
      start[3] = 1'b0;
      check("t3_per0_burst", 32'(busy[3]), 32'(0));

      // period shrink from 10 to 4 while cnt = 7
      set_ch(0, M_OFF, 10, 8, 0);
      step();
      align(2);
      set_ch(0, M_BLINK, 10, 8, 0);
      step();
      check("t4_start", 32'(led[0]), 32'(1));
      repeat (25) step();
      check("t4_cnt7", 32'(led[0]), 32'(1));
      set_ch(0, M_BLINK, 4, 1, 0);
      for (int i = 1; i <= 24; i++) begin
         step();
         check("t4_led0", 32'(led[0]), 32'((i >= 4) && (((i - 4) % 16) < 4)));
      end

      // reset mid-burst, then a reset glitch between edges
      set_ch(1, M_BURST, 2, 1, 3);
      start[1] = 1'b1;
      step();
      start[1] = 1'b0;
      check("t5_busy_pre", 32'(busy[1]), 32'(1));
      repeat (2) step();
      rst = 1'b1;
      step();
      k = 0;
      rst = 1'b0;
      check("t5_led",  32'(led),  32'(0));
      check("t5_busy", 32'(busy), 32'(0));
      check("t5_tick", 32'(tick), 32'(0));
      for (int i = 0; i < 8; i++) begin
         step();
         check("t5_tick_restart", 32'(tick), 32'((k % 4) == 3));
      end
      start[1] = 1'b1;
      step();
      start[1] = 1'b0;
      check("t5_busy_again", 32'(busy[1]), 32'(1));
      rst = 1'b1;
      #2;
      rst = 1'b0;
      step();
      check("t5_glitch_busy", 32'(busy[1]), 32'(1));
      for (int i = 0; i < 4; i++) begin
         check("t5_glitch_tick", 32'(tick), 32'((k % 4) == 3));
         step();
      end

      // independence: ch2 mode bounce must not disturb ch3 burst
      align(2);
      set_ch(0, M_ON, 4, 1, 0);
      set_ch(1, M_OFF, 2, 1, 3);
      set_ch(2, M_BLINK, 4, 2, 0);
      set_ch(3, M_BURST, 2, 1, 4);
      step();
      start[3] = 1'b1;
      step();
      start[3] = 1'b0;
      for (int j = 0; j < 36; j++) begin
         int  c2;
         logic e2;
         if (j <= 9)       begin c2 = (1 + j / 4) % 4; e2 = (c2 < 2); end
         else if (j <= 12) begin c2 = 0; e2 = 1'b1; end
         else              begin c2 = (j / 4 - 3) % 4; e2 = (c2 < 2); end
         check("t6_led0",  32'(led[0]),  32'(1));
         check("t6_led1",  32'(led[1]),  32'(0));
         check("t6_led2",  32'(led[2]),  32'(e2));
         check("t6_busy3", 32'(busy[3]), 32'(j < 32));
         check("t6_led3",  32'(led[3]),  32'((j < 32) && ((j / 4) % 2 == 0)));
         if (j == 9)  mode[5:4] = M_ON;
         if (j == 12) mode[5:4] = M_BLINK;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_blink_controller.md
Name: multi_blink_controller

Overview:
- N-channel LED pattern generator; parametrised successor of the single-channel blinker.
- One shared prescaler produces a periodic tick. Each channel runs its own tick-based phase counter.
- Per-channel modes: off, on, continuous blink with programmable period and on-time (duty), and triggered burst of N pulses.
- Sits between the control/register logic and the board LED pins.

Parameters:
N_CH, 4, number of independent LED channels
CNT_W, 16, width of period/on_time fields (units: ticks)
BURST_W, 8, width of burst_len field
TICK_DIV, 100000, clk cycles per tick (1 ms at 100 MHz); must be >=1

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
mode  input  2*N_CH  per channel: 00 off, 01 on, 10 blink, 11 burst
period  input  CNT_W*N_CH  per channel period in ticks
on_time  input  CNT_W*N_CH  per channel high time in ticks within period
burst_len  input  BURST_W*N_CH  pulses per burst (burst mode only)
start  input  N_CH  per channel single-cycle trigger for burst
led  output  N_CH  LED drive
busy  output  N_CH  burst in progress
tick  output  1  prescaler strobe, one clk wide

Behaviour:
- Reset (sampled on clk edge only):
  - prescaler count = 0; tick = 0.
  - All channel counters, remaining-pulse counts, stored mode copies and busy = 0; led = 0.
  - Reset mid-burst aborts the burst.
- Prescaler:
  - Counts 0..TICK_DIV-1.
  - tick = 1 for exactly the cycle in which count == TICK_DIV-1; the count then wraps to 0.
  - TICK_DIV = 1 means tick is high every cycle.
- Channel counter cnt:
  - Advances only on tick.
  - On tick, if cnt >= period-1, cnt wraps to 0 (a "wrap" event); otherwise cnt + 1.
  - The >= comparison guarantees a clean wrap when period shrinks below the current cnt.
- led (combinational from registered state, no extra latency):
  - off: 0.
  - on: 1.
  - blink: (cnt < on_time).
  - burst: (busy && cnt < on_time).
  - Consequences: on_time = 0 gives a constant 0; on_time >= period gives a constant 1.
- period = 0: channel disabled in blink/burst. cnt held at 0, led = 0, busy cleared, start ignored.
- Mode change: the registered copy of mode is compared each cycle. Any change forces cnt = 0 and busy = 0 on the next edge, so a new pattern always starts at phase 0.
- Burst state machine, per channel, states IDLE and RUN:
  - IDLE -> RUN: when mode = burst, start = 1, burst_len != 0 and period != 0. On that edge, cnt = 0, remaining = burst_len and busy = 1. led is valid the following cycle.
  - RUN, wrap event: remaining decrements. When remaining == 1 at a wrap, return to IDLE with busy = 0 and cnt = 0.
  - start while RUN: ignored (no retrigger).
  - start in any other mode: ignored.
  - burst_len = 0: start ignored.
  - burst_len change during RUN: does not affect the pulse count already loaded.
- Simultaneous events:
  - Mode change on the same edge as start: the mode change wins and the burst is not started.
  - rst has priority over everything.
- Channels are fully independent; they share only tick.

Test Plan:
1. TICK_DIV=4, ch0 blink, period=4, on_time=1 -> tick every 4 clks; led0 high 4 clks, low 12 clks, repeating; other channels (off) stay 0.
2. ch1 burst, period=2, on_time=1, burst_len=3, start pulse -> busy1 = 1 for 6 ticks; three 1-tick pulses on led1; then led1 = 0, busy1 = 0. A second start mid-burst leaves the pulse count at 3.
3. Boundaries -> on_time=0, period=4: led always 0. on_time=5, period=4: led always 1. period=0 in blink: led 0. burst_len=0 + start: busy stays 0.
4. Blink period=10 with cnt=7, period rewritten to 4 -> cnt wraps to 0 on the next tick; subsequent period is 4 ticks.
5. Reset: rst high for one clk mid-burst -> next cycle led = 0, busy = 0, tick count restarts. A rst glitch between clock edges has no effect.
6. Independence: ch0 on, ch1 off, ch2 blink, ch3 burst running together -> ch0 = 1, ch1 = 0. Switching ch2 to on then back to blink restarts only ch2's phase at cnt = 0; ch3's burst continues undisturbed.
